// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester arbiter/sequencer in front of the shared block-transfer memory.
// Requester 0 is the instruction-cache refill port. Requester 1 is the
// data-cache refill/writeback port. One block read or write is issued at a
// time. The memory request is held stable until the memory's done pulse. The
// read block and a one-cycle done pulse go back to the granted requester only.
//
// Optional feature (compile-time macro):
//   ARB_ROUND_ROBIN_EN - when defined, a contention is won by the requester
//                        that was not served last. When undefined, r1 always
//                        wins a contention (fixed priority).
//
// Ports:
//   m_clk_i, m_reset_i        clock (rising edge), async active-high reset
//   rX_read_i / rX_wr_i       level block read / write request, held to done
//   rX_addr_i, rX_wr_data_i   block address, write block
//   rX_read_data_o            registered read block (updates on own reads only)
//   rX_busywait_o             stall: request pending and not completing
//   rX_done_o                 registered one-cycle completion pulse
//   mem_read_o, mem_wr_o      registered memory request (held until done)
//   mem_addr_o, mem_wr_data_o registered memory block address / write block
//   mem_read_data_i           memory read block
//   mem_busywait_i            memory busy; no new grant while high
//   mem_read_done_i           memory read completion pulse
//   mem_write_done_i          memory write completion pulse
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned c_block_size = 2,
    parameter int unsigned c_line_size  = 32,
    parameter int unsigned address_size = 32
) (
    input  logic                                          m_clk_i,
    input  logic                                          m_reset_i,

    input  logic                                          r0_read_i,
    input  logic                                          r0_wr_i,
    input  logic [address_size-c_block_size-3:0]          r0_addr_i,
    input  logic [(c_line_size << c_block_size)-1:0]      r0_wr_data_i,
    output logic [(c_line_size << c_block_size)-1:0]      r0_read_data_o,
    output logic                                          r0_busywait_o,
    output logic                                          r0_done_o,

    input  logic                                          r1_read_i,
    input  logic                                          r1_wr_i,
    input  logic [address_size-c_block_size-3:0]          r1_addr_i,
    input  logic [(c_line_size << c_block_size)-1:0]      r1_wr_data_i,
    output logic [(c_line_size << c_block_size)-1:0]      r1_read_data_o,
    output logic                                          r1_busywait_o,
    output logic                                          r1_done_o,

    output logic                                          mem_read_o,
    output logic                                          mem_wr_o,
    output logic [address_size-c_block_size-3:0]          mem_addr_o,
    output logic [(c_line_size << c_block_size)-1:0]      mem_wr_data_o,
    input  logic [(c_line_size << c_block_size)-1:0]      mem_read_data_i,
    input  logic                                          mem_busywait_i,
    input  logic                                          mem_read_done_i,
    input  logic                                          mem_write_done_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state;
    logic   req0;
    logic   req1;
    logic   pick1;
    logic   op_done;

    assign req0 = r0_read_i | r0_wr_i;
    assign req1 = r1_read_i | r1_wr_i;

    // Stall drops in the completion cycle so the requester can retire.
    assign r0_busywait_o = req0 & ~r0_done_o;
    assign r1_busywait_o = req1 & ~r1_done_o;

    // Only the done pulse matching the issued op completes the grant.
    assign op_done = (mem_read_o & mem_read_done_i) | (mem_wr_o & mem_write_done_i);

`ifdef ARB_ROUND_ROBIN_EN
    // last1 = 1 means r1 was served last; on contention the other side wins.
    logic last1;
    assign pick1 = req1 & (~req0 | ~last1);
`else
    assign pick1 = req1;
`endif

    // Arbitration, memory request sequencing and requester return path.
    always_ff @(posedge m_clk_i or posedge m_reset_i) begin
        if (m_reset_i) begin
            state          <= IDLE;
            mem_read_o     <= 1'b0;
            mem_wr_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wr_data_o  <= '0;
            r0_done_o      <= 1'b0;
            r1_done_o      <= 1'b0;
            r0_read_data_o <= '0;
            r1_read_data_o <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last1          <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!mem_busywait_i && (req0 || req1)) begin
                        // Read wins over write when both are raised together.
                        if (pick1) begin
                            mem_read_o    <= r1_read_i;
                            mem_wr_o      <= ~r1_read_i;
                            mem_addr_o    <= r1_addr_i;
                            mem_wr_data_o <= r1_wr_data_i;
                            state         <= GRANT1;
                        end else begin
                            mem_read_o    <= r0_read_i;
                            mem_wr_o      <= ~r0_read_i;
                            mem_addr_o    <= r0_addr_i;
                            mem_wr_data_o <= r0_wr_data_i;
                            state         <= GRANT0;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last1 <= pick1;
`endif
                    end
                end
                GRANT0, GRANT1: begin
                    if (op_done) begin
                        mem_read_o <= 1'b0;
                        mem_wr_o   <= 1'b0;
                        if (state == GRANT0) begin
                            r0_done_o <= 1'b1;
                            if (mem_read_o) begin
                                r0_read_data_o <= mem_read_data_i;
                            end
                        end else begin
                            r1_done_o <= 1'b1;
                            if (mem_read_o) begin
                                r1_read_data_o <= mem_read_data_i;
                            end
                        end
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    r0_done_o <= 1'b0;
                    r1_done_o <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single shared block-transfer memory.
- Requester 0 is the instruction cache refill port; requester 1 is the data cache refill/writeback port.
- Grants one block read or block write at a time and holds the memory request stable until the memory's done pulse.
- Returns the read block and a one-cycle done pulse to the granted requester only.

Parameters:
- c_block_size, 2, log2 words per block.
- c_line_size, 32, bits per word.
- address_size, 32, byte address width.
- Derived: A = address_size - c_block_size - 2 (block address width, 28 at defaults); D = 2**c_block_size * c_line_size (block data width, 128 at defaults).

Ports:
- m_clk_i  in  1  clock, rising edge.
- m_reset_i  in  1  asynchronous, active-high reset.
- r0_read_i  in  1  requester 0 block read request, level, held until r0_done_o.
- r0_wr_i  in  1  requester 0 block write request, level, held until r0_done_o.
- r0_addr_i  in  A  requester 0 block address.
- r0_wr_data_i  in  D  requester 0 write block.
- r0_read_data_o  out  D  requester 0 read block, registered.
- r0_busywait_o  out  1  requester 0 stall.
- r0_done_o  out  1  requester 0 completion pulse, registered.
- r1_*  same seven ports as requester 0, for requester 1.
- mem_read_o  out  1  memory read request.
- mem_wr_o  out  1  memory write request.
- mem_addr_o  out  A  memory block address.
- mem_wr_data_o  out  D  memory write block.
- mem_read_data_i  in  D  memory read block.
- mem_busywait_i  in  1  memory busy.
- mem_read_done_i  in  1  memory read completion pulse.
- mem_write_done_i  in  1  memory write completion pulse.

Behaviour:
- Reset (async): state IDLE. All mem_* outputs, rX_done_o and rX_read_data_o are 0. Priority pointer points to r1.
- Request: reqX = rX_read_i | rX_wr_i. Read and write asserted together counts as a read; the write is ignored.
- Busywait: rX_busywait_o = reqX & ~rX_done_o (combinational).
- IDLE:
  - If mem_busywait_i = 0 and any reqX: choose a winner (fixed priority r1 > r0 unless the optional feature is enabled).
  - At the edge, register the winner's op, address and write data into the mem_* outputs and go to GRANT0 or GRANT1.
  - With no request, stay in IDLE.
- GRANTx:
  - Hold mem_read_o/mem_wr_o, mem_addr_o and mem_wr_data_o constant; later changes on the rX_* inputs are ignored.
  - When the done pulse for the issued op arrives (mem_read_done_i for a read, mem_write_done_i for a write), clear mem_read_o/mem_wr_o at that edge, so the memory sees them low when it returns to idle.
  - On a read, also capture mem_read_data_i into rX_read_data_o.
  - Set rX_done_o = 1 and go to RELEASE.
  - A done pulse for the other op type is ignored.
- RELEASE (1 cycle):
  - rX_done_o is high for exactly this cycle.
  - The granted requester drops its request at the end of this cycle; its request is masked from arbitration.
  - Next state IDLE; rX_done_o returns to 0.
- rX_read_data_o changes only on requester X read completion and holds otherwise, including across writes and the other requester's reads.
- Latency with the team memory at defaults:
  - Request asserted in cycle 0 gives mem_read_o/mem_wr_o high from cycle 1, memory done in cycle 6, rX_done_o in cycle 7.
  - Back-to-back transactions are separated by at least 1 IDLE cycle.
- Simultaneous requests: one requester is served; the loser keeps busywait high and is served on the next arbitration.
- Request withdrawn before grant: no action. Withdrawal after grant is a protocol violation; the transaction still completes and done still pulses.
- Reset mid-transaction: immediate return to IDLE with outputs cleared. The memory shares m_reset_i, so no partial transfer is resumed.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit pointer holds the last-served requester. When both request in IDLE, the other requester wins; the pointer updates on each grant and resets to "last = r1", so r0 wins the first contention.
- Not defined: fixed priority, r1 always wins contention; no pointer register.

Test Plan:
- Single r0 read at addr 0x0000010 (memory words 0x40..0x43 = 0x11,0x22,0x33,0x44) -> mem_read_o high cycles 1..6, r0_done_o pulse in cycle 7, r0_read_data_o = {0x44,0x33,0x22,0x11}, r1_read_data_o unchanged at 0.
- r1 write of 0xDEADBEEF_CAFEF00D_01234567_89ABCDEF to addr 0x0000002, then r1 read of the same addr -> mem_wr_o then mem_read_o sequence with one IDLE gap; read returns an identical block and each r1_done_o is one cycle wide.
- r0 and r1 both read in the same cycle, macro off -> r1 served first; r0_busywait_o stays high until r0_done_o about 8 cycles later; three repeated contentions always serve r1 first.
- Same contention with ARB_ROUND_ROBIN_EN -> first grant r0, then r1, then alternating over 4 contentions.
- Assert m_reset_i in cycle 3 of an r0 read -> all outputs 0 in that cycle, state IDLE, no r0_done_o pulse; a new request after reset completes normally.
- r1 asserts read and write together -> only mem_read_o asserted, mem_wr_o stays 0; a stray mem_write_done_i during the read grant is ignored.
